// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg : shared widths and per-stage control vectors             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pipe_pkg;

  localparam int PIPE_CTRL_W = 16;
  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CNT_W  = 16;

  // Each stage view is padded to exactly PIPE_CTRL_W bits so any of them fits the generic vector.
  typedef struct packed {
    logic [14:0] rsvd;
    logic        pred_taken;
  } if_id_ctrl_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic [4:0] rsvd;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       mem_to_reg;
    logic [2:0] mem_size;
    logic [8:0] rsvd;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic        reg_wr;
    logic        mem_to_reg;
    logic [13:0] rsvd;
  } mem_wb_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter : saturating up-counter with synchronous clear         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_stage_reg : generic pipeline stage register, valid/ready,     |
// |   stall/flush, perf counters. PIPE_SKID_EN adds a skid entry.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = PIPE_CTRL_W,
  parameter int DATA_W     = PIPE_DATA_W,
  parameter int CNT_W      = PIPE_CNT_W,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              w_accept, w_pop, w_out_valid, w_in_ready;

  // A flushed or reset entry is never offered downstream, even in its final cycle.
  assign w_out_valid = main_valid_q & ~stall & ~flush & ~rst;
  assign w_pop       = w_out_valid & out_ready;
  assign w_accept    = in_valid & w_in_ready;

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  assign w_in_ready = ~rst & ~stall & ~flush & ~skid_valid_q;
  assign occupancy  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
`else
  assign w_in_ready = ~rst & ~stall & ~flush & (~main_valid_q | out_ready);
  assign occupancy  = {1'b0, main_valid_q};
`endif

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
`ifdef PIPE_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
`endif
    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      if (CLEAR_DATA) main_data_d = '0;
`ifdef PIPE_SKID_EN
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      if (CLEAR_DATA) skid_data_d = '0;
`endif
    end else if (!stall) begin
`ifdef PIPE_SKID_EN
      if (skid_valid_q) begin
        if (w_pop) begin
          main_valid_d = 1'b1;
          main_ctrl_d  = skid_ctrl_q;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
          skid_ctrl_d  = '0;
        end
      end else if (main_valid_q && !w_pop) begin
        if (w_accept) begin
          skid_valid_d = 1'b1;
          skid_ctrl_d  = in_ctrl;
          skid_data_d  = in_data;
        end
      end else if (w_accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else if (w_pop) begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
`else
      if (w_accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else if (w_pop) begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
`ifdef PIPE_SKID_EN
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
`endif
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
`ifdef PIPE_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
`endif
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_ctrl  = w_out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;

  logic w_stall_inc, w_bubble_inc;
  assign w_stall_inc  = stall & ~rst;
  assign w_bubble_inc = ~main_valid_q & out_ready & ~stall & ~flush;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .inc_i   (w_stall_inc),
    .count_o (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .inc_i   (w_bubble_inc),
    .count_o (bubble_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_stage_reg : directed bench for pipe_stage_reg (CNT_W = 4)  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pipe_stage_reg;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst, flush, stall, cnt_clr;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .CLEAR_DATA(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = DATA_W'(d);
    in_ctrl  = 16'h0100 | CTRL_W'(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0;
    drive(1'b1, 8'h99);
    cyc(); cyc();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_bubble_cnt", bubble_cnt, 0);
    check("rst_out_data", out_data, 0);

    // Streaming
    rst = 1'b0; drive(1'b1, 8'h11);
    cyc(); out_ready = 1'b1; drive(1'b1, 8'h22); #1;
    check("stream_v0", out_valid, 1);
    check("stream_d0", out_data, 128'h11);
    check("stream_c0", out_ctrl, 16'h0111);
    check("stream_rdy", in_ready, 1);
    cyc(); drive(1'b1, 8'h33); #1;
    check("stream_d1", out_data, 128'h22);
    cyc(); drive(1'b0, 8'h00); #1;
    check("stream_d2", out_data, 128'h33);
    check("stream_v2", out_valid, 1);
    cyc(); #1;
    check("stream_empty", out_valid, 0);
    check("stream_bubble", bubble_cnt, 0);
    cyc(); out_ready = 1'b0; #1;
    check("bubble_one", bubble_cnt, 1);

    // Backpressure
    drive(1'b1, 8'h0A);
    cyc(); drive(1'b1, 8'h0B); #1;
    check("bp_head", out_data, 128'h0A);
`ifdef PIPE_SKID_EN
    check("bp_rdy_skid_free", in_ready, 1);
    cyc(); drive(1'b0, 8'h00); #1;
    check("bp_occ2", occupancy, 2);
    check("bp_rdy0", in_ready, 0);
    out_ready = 1'b1; #1;
    check("bp_pop_a", out_data, 128'h0A);
    cyc(); #1;
    check("bp_pop_b", out_data, 128'h0B);
    check("bp_occ1", occupancy, 1);
    cyc(); out_ready = 1'b0; #1;
    check("bp_drained", out_valid, 0);
`else
    check("bp_occ1", occupancy, 1);
    check("bp_rdy0", in_ready, 0);
    out_ready = 1'b1; #1;
    check("bp_rdy_pass", in_ready, 1);
    cyc(); drive(1'b0, 8'h00); #1;
    check("bp_pop_b", out_data, 128'h0B);
    cyc(); out_ready = 1'b0; #1;
    check("bp_drained", out_valid, 0);
`endif

    // Stall with entry 0x5 held
    drive(1'b1, 8'h05);
    cyc(); drive(1'b0, 8'h00); stall = 1'b1; out_ready = 1'b1; #1;
    check("stall_ov", out_valid, 0);
    check("stall_ctrl", out_ctrl, 0);
    check("stall_rdy", in_ready, 0);
    cyc(); cyc(); cyc(); #1;
    check("stall_frozen", out_data, 128'h05);
    stall = 1'b0; #1;
    check("stall_cnt3", stall_cnt, 3);
    check("stall_release_v", out_valid, 1);
    check("stall_release_c", out_ctrl, 16'h0105);
    cyc(); out_ready = 1'b0; #1;
    check("stall_popped", out_valid, 0);

    // Flush with in_valid
    drive(1'b1, 8'h07);
    cyc(); drive(1'b1, 8'h08); flush = 1'b1; #1;
    check("flush_rdy", in_ready, 0);
    cyc(); flush = 1'b0; drive(1'b0, 8'h00); #1;
    check("flush_ov", out_valid, 0);
    check("flush_ctrl", out_ctrl, 0);
    check("flush_data", out_data, 0);
    check("flush_occ", occupancy, 0);
    cyc(); #1;
    check("flush_lost", out_valid, 0);

    // Saturation at CNT_W = 4
    cnt_clr = 1'b1;
    cyc(); cnt_clr = 1'b0; #1;
    check("clr_bubble", bubble_cnt, 0);
    stall = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    #1;
    check("sat_stall", stall_cnt, 15);
    cnt_clr = 1'b1;
    cyc(); #1;
    check("clr_over_inc", stall_cnt, 0);
    cnt_clr = 1'b0; stall = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
